// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the keypad row debouncer and for the scanner-side
// verification monitors that decode the per-row debounce state.
//   NUM_ROWS    number of keypad row lines
//   db_state_t  per-row debounce FSM state
//   cnt_width   width needed to hold the larger of the two debounce windows
// -----------------------------------------------------------------------------
package keypad_pkg;

  localparam int NUM_ROWS = 4;

  typedef enum logic [1:0] {
    DB_LOW,
    DB_RISE_WAIT,
    DB_HIGH,
    DB_REL_WAIT
  } db_state_t;

  function automatic int cnt_width(input int release_cycles, input int rise_cycles);
    int max_cycles;
    max_cycles = (release_cycles > rise_cycles) ? release_cycles : rise_cycles;
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/keypad_row_debouncer_if.sv
// -----------------------------------------------------------------------------
// keypad_row_debouncer_if
// Row bus between the raw keypad lines, the debouncer and the scanner FSM.
//   row_raw        raw asynchronous rows (driven by the master side)
//   row_d          debounced rows
//   any_row        OR of row_d
//   release_pulse  one-cycle all-rows-released strobe
// Modports: master = environment/scanner side, slave = debouncer.
// -----------------------------------------------------------------------------
interface keypad_row_debouncer_if;
  import keypad_pkg::*;

  logic [NUM_ROWS-1:0] row_raw;
  logic [NUM_ROWS-1:0] row_d;
  logic                any_row;
  logic                release_pulse;

  modport master (output row_raw, input row_d, input any_row, input release_pulse);
  modport slave  (input row_raw, output row_d, output any_row, output release_pulse);

endinterface

// File: rtl/row_debounce_bit.sv
// -----------------------------------------------------------------------------
// row_debounce_bit
// One keypad row: SYNC_STAGES-deep synchronizer followed by a fast-attack /
// slow-release debounce FSM with a saturating cycle counter.
// Optional macro KEYPAD_RISE_DEBOUNCE_EN adds a RISE_WAIT state so a rise
// also needs RISE_CYCLES consecutive high samples.
// Ports:
//   clk      in   system clock
//   nrst     in   synchronous active-low reset
//   row_raw  in   raw asynchronous row line
//   row_d    out  debounced row, registered
// -----------------------------------------------------------------------------
module row_debounce_bit
  import keypad_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int RELEASE_CYCLES = 50000,
  parameter int RISE_CYCLES    = 8
) (
  input  logic clk,
  input  logic nrst,
  input  logic row_raw,
  output logic row_d
);

  localparam int CNT_W = cnt_width(RELEASE_CYCLES, RISE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   row_s;
  db_state_t              state, state_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic                   row_d_n;

  // Plain shift chain: nothing may sit between synchronizer flops.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!nrst) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], row_raw};
  end

  assign row_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= DB_LOW;
      cnt   <= '0;
      row_d <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      row_d <= row_d_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      DB_LOW: begin
        cnt_n = '0;
`ifdef KEYPAD_RISE_DEBOUNCE_EN
        if (row_s) begin
          state_n = DB_RISE_WAIT;
          cnt_n   = CNT_W'(1);
        end
`else
        if (row_s) state_n = DB_HIGH;
`endif
      end
      DB_RISE_WAIT: begin
`ifdef KEYPAD_RISE_DEBOUNCE_EN
        if (!row_s) begin
          state_n = DB_LOW;
          cnt_n   = '0;
        end else if (cnt == CNT_W'(RISE_CYCLES - 1)) begin
          state_n = DB_HIGH;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
`else
        // Unreachable without the rise filter; fall back to a safe state.
        state_n = DB_LOW;
        cnt_n   = '0;
`endif
      end
      DB_HIGH: begin
        cnt_n = '0;
        if (!row_s) begin
          state_n = DB_REL_WAIT;
          cnt_n   = CNT_W'(1);
        end
      end
      DB_REL_WAIT: begin
        if (row_s) begin
          // Bounce absorbed: any high sample restarts the release window.
          state_n = DB_HIGH;
          cnt_n   = '0;
        end else if (cnt == CNT_W'(RELEASE_CYCLES - 1)) begin
          state_n = DB_LOW;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
    endcase
    row_d_n = (state_n == DB_HIGH) || (state_n == DB_REL_WAIT);
  end

endmodule

// File: rtl/keypad_row_debouncer.sv
// -----------------------------------------------------------------------------
// keypad_row_debouncer
// Conditions the NUM_ROWS raw keypad rows for the column scanner: per-row
// synchronize + debounce, plus any_row and a one-cycle release_pulse when the
// debounced bus goes from nonzero to all-zero.
// Optional macro KEYPAD_RISE_DEBOUNCE_EN enables rise debouncing in each row.
// Ports:
//   clk   in   system clock
//   nrst  in   synchronous active-low reset
//   bus   slave modport of keypad_row_debouncer_if
//           row_raw in, row_d out (registered), any_row out (|row_d),
//           release_pulse out (registered)
// -----------------------------------------------------------------------------
module keypad_row_debouncer
  import keypad_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int RELEASE_CYCLES = 50000,
  parameter int RISE_CYCLES    = 8
) (
  input logic                    clk,
  input logic                    nrst,
  keypad_row_debouncer_if.slave  bus
);

  logic [NUM_ROWS-1:0] row_d;
  logic                any_row_q;
  logic                release_q;

  for (genvar i = 0; i < NUM_ROWS; i++) begin : g_rows
    row_debounce_bit #(
      .SYNC_STAGES   (SYNC_STAGES),
      .RELEASE_CYCLES(RELEASE_CYCLES),
      .RISE_CYCLES   (RISE_CYCLES)
    ) u_bit (
      .clk    (clk),
      .nrst   (nrst),
      .row_raw(bus.row_raw[i]),
      .row_d  (row_d[i])
    );
  end

  // any_row_q remembers last cycle's bus state; the strobe fires on the clock
  // after the bus drops to zero. Reset clears any_row_q, so reset never
  // produces a strobe.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      any_row_q <= 1'b0;
      release_q <= 1'b0;
    end else begin
      any_row_q <= |row_d;
      release_q <= any_row_q & ~(|row_d);
    end
  end

  assign bus.row_d         = row_d;
  assign bus.any_row       = |row_d;
  assign bus.release_pulse = release_q;

endmodule

// File: tb/tb_keypad_row_debouncer.sv
// -----------------------------------------------------------------------------
// tb_keypad_row_debouncer
// Directed bench for keypad_row_debouncer with SYNC_STAGES=2,
// RELEASE_CYCLES=16, RISE_CYCLES=8. Inputs are driven and outputs sampled on
// the falling clock edge; step(n) advances exactly n rising edges.
// Honours KEYPAD_RISE_DEBOUNCE_EN when compiled with it.
// -----------------------------------------------------------------------------
module tb_keypad_row_debouncer;
  import keypad_pkg::*;

  localparam int SS   = 2;
  localparam int RC   = 16;
  localparam int RISE = 8;
`ifdef KEYPAD_RISE_DEBOUNCE_EN
  localparam int RISE_LAT = SS + RISE;
`else
  localparam int RISE_LAT = SS + 1;
`endif

  logic clk = 1'b0;
  logic nrst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  keypad_row_debouncer_if bus ();

  keypad_row_debouncer #(
    .SYNC_STAGES   (SS),
    .RELEASE_CYCLES(RC),
    .RISE_CYCLES   (RISE)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    nrst        = 1'b0;
    bus.row_raw = '0;
    step(2);
    nrst = 1'b1;
    step(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- 1: reset holds outputs low, then fast attack on all rows ----
    nrst        = 1'b0;
    bus.row_raw = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("rst_row_d", bus.row_d, 4'b0000);
      check("rst_pulse", bus.release_pulse, 1'b0);
    end
    check("rst_any_row", bus.any_row, 1'b0);
    nrst = 1'b1;
    step(RISE_LAT - 1);
    check("attack_early", bus.row_d, 4'b0000);
    step(1);
    check("attack_on_time", bus.row_d, 4'b1111);
    check("attack_any_row", bus.any_row, 1'b1);

`ifndef KEYPAD_RISE_DEBOUNCE_EN
    // ---- 2: single-cycle press on row 1 ----
    do_reset();
    bus.row_raw = 4'b0010;
    step(1);
    bus.row_raw = 4'b0000;
    step(1);
    check("pulse1_before_rise", bus.row_d, 4'b0000);
    step(1);
    check("pulse1_rise", bus.row_d, 4'b0010);
    step(15);
    check("pulse1_still_high", bus.row_d, 4'b0010);
    check("pulse1_no_strobe_yet", bus.release_pulse, 1'b0);
    step(1);
    check("pulse1_fall", bus.row_d, 4'b0000);
    check("pulse1_no_strobe_at_fall", bus.release_pulse, 1'b0);
    step(1);
    check("pulse1_strobe", bus.release_pulse, 1'b1);
    step(1);
    check("pulse1_strobe_one_cycle", bus.release_pulse, 1'b0);
`endif

    // ---- 3: release bounce on row 3 ----
    do_reset();
    bus.row_raw = 4'b1000;
    step(12);
    check("bounce_held", bus.row_d, 4'b1000);
    for (int k = 0; k < 40; k++) begin
      bus.row_raw[3] = ((k / 3) % 2) == 1;
      step(1);
      check("bounce_row_d", bus.row_d, 4'b1000);
      check("bounce_no_strobe", bus.release_pulse, 1'b0);
    end
    bus.row_raw = 4'b0000;
    step(RC + SS - 1);
    check("bounce_before_fall", bus.row_d, 4'b1000);
    step(1);
    check("bounce_fall", bus.row_d, 4'b0000);
    check("bounce_any_row_low", bus.any_row, 1'b0);
    step(1);
    check("bounce_strobe", bus.release_pulse, 1'b1);
    step(1);
    check("bounce_strobe_once", bus.release_pulse, 1'b0);

    // ---- 4: overlapping rows 0 and 2 ----
    do_reset();
    bus.row_raw = 4'b0101;
    step(12);
    check("overlap_held", bus.row_d, 4'b0101);
    bus.row_raw = 4'b0100;
    step(10);
    bus.row_raw = 4'b0000;
    step(7);
    check("overlap_before_row0_fall", bus.row_d, 4'b0101);
    step(1);
    check("overlap_row0_fall", bus.row_d, 4'b0100);
    check("overlap_no_strobe_a", bus.release_pulse, 1'b0);
    step(1);
    check("overlap_no_strobe_b", bus.release_pulse, 1'b0);
    step(8);
    check("overlap_before_row2_fall", bus.row_d, 4'b0100);
    step(1);
    check("overlap_row2_fall", bus.row_d, 4'b0000);
    step(1);
    check("overlap_strobe", bus.release_pulse, 1'b1);
    step(1);
    check("overlap_strobe_once", bus.release_pulse, 1'b0);

    // ---- 5: reset while row 1 is counting down its release ----
    do_reset();
    bus.row_raw = 4'b0010;
    step(12);
    bus.row_raw = 4'b0000;
    step(10);
    check("midrst_cnt_before", 32'(dut.g_rows[1].u_bit.cnt), 32'd8);
    check("midrst_row_d_before", bus.row_d, 4'b0010);
    nrst = 1'b0;
    step(1);
    check("midrst_row_d", bus.row_d, 4'b0000);
    check("midrst_cnt", 32'(dut.g_rows[1].u_bit.cnt), 32'd0);
    check("midrst_no_strobe", bus.release_pulse, 1'b0);
    nrst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step(1);
      check("midrst_after_no_strobe", bus.release_pulse, 1'b0);
    end
    check("midrst_after_row_d", bus.row_d, 4'b0000);

`ifdef KEYPAD_RISE_DEBOUNCE_EN
    // ---- 6: rise filter rejects short pulses, accepts RISE_CYCLES ----
    do_reset();
    bus.row_raw = 4'b0001;
    step(5);
    bus.row_raw = 4'b0000;
    for (int k = 0; k < 15; k++) begin
      step(1);
      check("rise_short_rejected", bus.row_d, 4'b0000);
    end
    bus.row_raw = 4'b0001;
    step(8);
    bus.row_raw = 4'b0000;
    step(1);
    check("rise_before", bus.row_d, 4'b0000);
    step(1);
    check("rise_on_time", bus.row_d, 4'b0001);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
